// File: rtl/risc16_mem_arbiter.sv
// Arbitrates one single-ported synchronous memory between the risc16f fetch and data
// ports, with a one-entry posted write buffer, read forwarding and an I/O window.
module risc16_mem_arbiter #(
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] IO_BASE      = 16'h0200,
  parameter logic [ADDR_W-1:0] IO_MASK      = 16'hFF00,
  parameter int                STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [15:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [15:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [15:0]       d_rdata,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              io_en,
  output logic              io_we,
  output logic [7:0]        io_addr,
  output logic [15:0]       io_wdata,
  input  logic [15:0]       io_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {
    TAG_NONE,
    TAG_IMEM,
    TAG_DMEM,
    TAG_DIO,
    TAG_DFWD
  } tag_t;

  // A fetch can complete alongside a forwarded or I/O read, so each port has its own slot.
  tag_t i_tag;
  tag_t d_tag;

  logic              wbuf_v;
  logic [ADDR_W-2:0] wbuf_addr;
  logic [15:0]       wbuf_data;
  logic [15:0]       fwd_data;
  logic [15:0]       i_rdata_q;
  logic [15:0]       d_rdata_q;
  logic [SW-1:0]     starve_cnt;

  logic              live;
  logic [ADDR_W-2:0] i_word;
  logic [ADDR_W-2:0] d_word;
  logic              d_is_io;
  logic              fwd_hit;
  logic              d_mem_rd;
  logic              d_mem_wr;
  logic              starved;
  logic              s0, p1, p2, p3, p4;
  logic              drain;
  logic              wr_acc;
  logic              fwd_acc;
  logic              io_acc;

  assign live    = ~rst;
  assign i_word  = (ADDR_W-1)'(i_addr >> 1);
  assign d_word  = (ADDR_W-1)'(d_addr >> 1);
  assign d_is_io = ((d_addr & IO_MASK) == IO_BASE);
  assign starved = (starve_cnt == SW'(STARVE_LIMIT));

  always_comb begin
    fwd_hit  = d_req & ~d_we & ~d_is_io & wbuf_v & (d_word == wbuf_addr);
    d_mem_rd = d_req & ~d_we & ~d_is_io & ~fwd_hit;
    d_mem_wr = d_req & d_we & ~d_is_io;

    s0 = live & i_req & starved;
    p1 = live & ~s0 & d_mem_rd;
    p2 = live & ~s0 & ~p1 & wbuf_v & d_mem_wr;
    p3 = live & ~s0 & ~p1 & ~p2 & i_req;
    p4 = live & ~s0 & ~p1 & ~p2 & ~p3 & wbuf_v;
    drain = p2 | p4;

    wr_acc  = live & d_mem_wr & (~wbuf_v | drain);
    fwd_acc = live & fwd_hit;
    io_acc  = live & d_req & d_is_io & ~wbuf_v;

    i_gnt = s0 | p3;
    d_gnt = p1 | wr_acc | fwd_acc | io_acc;
    stall = (i_req & ~i_gnt) | (d_req & ~d_gnt);

    mem_en    = i_gnt | p1 | drain;
    mem_we    = drain;
    mem_wdata = wbuf_data;
    if (drain)
      mem_addr = wbuf_addr;
    else if (p1)
      mem_addr = d_word;
    else
      mem_addr = i_word;

    io_en    = io_acc;
    io_we    = io_acc & d_we;
    io_addr  = d_addr[7:0];
    io_wdata = d_wdata;
  end

  always_comb begin
    i_rvalid = live & (i_tag == TAG_IMEM);
    i_rdata  = i_rvalid ? mem_rdata : i_rdata_q;

    d_rvalid = live & (d_tag != TAG_NONE);
    d_rdata  = d_rdata_q;
    if (live) begin
      case (d_tag)
        TAG_DMEM: d_rdata = mem_rdata;
        TAG_DIO:  d_rdata = io_rdata;
        TAG_DFWD: d_rdata = fwd_data;
        default:  d_rdata = d_rdata_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbuf_v     <= 1'b0;
      wbuf_addr  <= '0;
      wbuf_data  <= '0;
      fwd_data   <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      starve_cnt <= '0;
      i_tag      <= TAG_NONE;
      d_tag      <= TAG_NONE;
    end else begin
      if (wr_acc) begin
        wbuf_v    <= 1'b1;
        wbuf_addr <= d_word;
        wbuf_data <= d_wdata;
      end else if (drain) begin
        wbuf_v <= 1'b0;
      end

      if (fwd_acc)
        fwd_data <= wbuf_data;

      i_rdata_q <= i_rdata;
      d_rdata_q <= d_rdata;

      i_tag <= i_gnt ? TAG_IMEM : TAG_NONE;

      if (p1)
        d_tag <= TAG_DMEM;
      else if (fwd_acc)
        d_tag <= TAG_DFWD;
      else if (io_acc & ~d_we)
        d_tag <= TAG_DIO;
      else
        d_tag <= TAG_NONE;

      if (~i_req | i_gnt)
        starve_cnt <= '0;
      else if (!starved)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_risc16_mem_arbiter.sv
// Directed bench for risc16_mem_arbiter: expected read data is queued at issue and
// compared by a monitor whenever an rvalid appears; grants and strobes are checked inline.
module tb_risc16_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [15:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [15:0] d_rdata;
  logic        stall;
  logic        mem_en;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        io_en;
  logic        io_we;
  logic [7:0]  io_addr;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] iq[$];
  logic [15:0] dq[$];

  logic [15:0] mem [0:32767];
  logic [15:0] io_mem [0:1];

  risc16_mem_arbiter #(
    .ADDR_W(16),
    .IO_BASE(16'h0200),
    .IO_MASK(16'hFF00),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .stall(stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .io_en(io_en), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: synchronous single-port memory and two LED registers.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
    if (io_en) begin
      if (io_we) io_mem[io_addr[1]] <= io_wdata;
      else       io_rdata <= io_mem[io_addr[1]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (i_rvalid) begin
      if (iq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL i_unexpected: got rvalid data %h expected no return", i_rdata);
      end else begin
        chk("i_rdata", {16'h0, i_rdata}, {16'h0, iq.pop_front()});
      end
    end
    if (d_rvalid) begin
      if (dq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL d_unexpected: got rvalid data %h expected no return", d_rdata);
      end else begin
        chk("d_rdata", {16'h0, d_rdata}, {16'h0, dq.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic dset(input logic req, input logic we, input logic [15:0] a, input logic [15:0] wd);
    d_req = req; d_we = we; d_addr = a; d_wdata = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  logic [15:0] t4_addr [0:3];
  logic [15:0] t4_data [0:3];

  initial begin
    for (int unsigned k = 0; k < 32768; k++) mem[k] = '0;
    mem[15'h008] = 16'h1234;
    mem[15'h009] = 16'h9999;
    mem[15'h00A] = 16'hAAAA;
    mem[15'h020] = 16'h1111;
    mem[15'h040] = 16'h4444;
    mem[15'h080] = 16'h5678;
    io_mem[0] = 16'h0000;
    io_mem[1] = 16'h5A5A;
    mem_rdata = '0;
    io_rdata  = '0;
    t4_addr[0] = 16'h0100; t4_data[0] = 16'h5678;
    t4_addr[1] = 16'h0012; t4_data[1] = 16'h9999;
    t4_addr[2] = 16'h0100; t4_data[2] = 16'h5678;
    t4_addr[3] = 16'h0012; t4_data[3] = 16'h9999;

    // reset with a fetch pending: nothing may be granted
    rst = 1'b1; i_req = 1'b1; i_addr = 16'h0010; dset(1'b0, 1'b0, 16'h0, 16'h0);
    sample();
    chk("rst_i_gnt", {31'h0, i_gnt}, 32'h0);
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h0);
    tick();
    rst = 1'b0; i_req = 1'b0;
    sample();
    chk("rst_i_rdata", {16'h0, i_rdata}, 32'h0);
    chk("rst_d_rdata", {16'h0, d_rdata}, 32'h0);
    tick();

    // 1: single fetch
    i_req = 1'b1; i_addr = 16'h0010; iq.push_back(16'h1234);
    sample();
    chk("t1_i_gnt", {31'h0, i_gnt}, 32'h1);
    chk("t1_mem_addr", {17'h0, mem_addr}, 32'h008);
    chk("t1_mem_we", {31'h0, mem_we}, 32'h0);
    tick();
    i_req = 1'b0;
    sample();
    chk("t1_i_rvalid", {31'h0, i_rvalid}, 32'h1);
    tick();

    // 2: data read beats fetch
    i_req = 1'b1; i_addr = 16'h0012; dset(1'b1, 1'b0, 16'h0100, 16'h0);
    dq.push_back(16'h5678); iq.push_back(16'h9999);
    sample();
    chk("t2_d_gnt", {31'h0, d_gnt}, 32'h1);
    chk("t2_i_gnt", {31'h0, i_gnt}, 32'h0);
    chk("t2_stall", {31'h0, stall}, 32'h1);
    chk("t2_mem_addr", {17'h0, mem_addr}, 32'h080);
    tick();
    d_req = 1'b0;
    sample();
    chk("t2_i_gnt2", {31'h0, i_gnt}, 32'h1);
    tick();
    i_req = 1'b0;
    sample();
    tick();

    // 3: posted write, forwarded read, opportunistic drain
    i_req = 1'b1; i_addr = 16'h0014; dset(1'b1, 1'b1, 16'h0040, 16'hBEEF);
    iq.push_back(16'hAAAA);
    sample();
    chk("t3_wr_d_gnt", {31'h0, d_gnt}, 32'h1);
    chk("t3_wr_mem_we", {31'h0, mem_we}, 32'h0);
    chk("t3_wr_i_gnt", {31'h0, i_gnt}, 32'h1);
    tick();
    dset(1'b1, 1'b0, 16'h0040, 16'h0);
    dq.push_back(16'hBEEF); iq.push_back(16'hAAAA);
    sample();
    chk("t3_fwd_d_gnt", {31'h0, d_gnt}, 32'h1);
    chk("t3_fwd_mem_addr", {17'h0, mem_addr}, 32'h00A);
    chk("t3_fwd_mem_we", {31'h0, mem_we}, 32'h0);
    tick();
    i_req = 1'b0; d_req = 1'b0;
    sample();
    chk("t3_drain", {30'h0, mem_en, mem_we}, 32'h3);
    chk("t3_drain_addr", {17'h0, mem_addr}, 32'h020);
    chk("t3_drain_data", {16'h0, mem_wdata}, 32'hBEEF);
    tick();
    sample();
    tick();
    dset(1'b1, 1'b0, 16'h0040, 16'h0); dq.push_back(16'hBEEF);
    sample();
    chk("t3_rd_mem_addr", {17'h0, mem_addr}, 32'h020);
    tick();
    d_req = 1'b0;
    sample();
    tick();

    // 4: starvation guard
    i_req = 1'b1; i_addr = 16'h0010;
    for (int k = 0; k < 4; k++) begin
      dset(1'b1, 1'b0, t4_addr[k], 16'h0); dq.push_back(t4_data[k]);
      sample();
      chk($sformatf("t4_i_gnt%0d", k), {31'h0, i_gnt}, 32'h0);
      chk($sformatf("t4_d_gnt%0d", k), {31'h0, d_gnt}, 32'h1);
      tick();
    end
    dset(1'b1, 1'b0, 16'h0100, 16'h0);
    dq.push_back(16'h5678); iq.push_back(16'h1234);
    sample();
    chk("t4_starve_i_gnt", {31'h0, i_gnt}, 32'h1);
    chk("t4_starve_d_gnt", {31'h0, d_gnt}, 32'h0);
    chk("t4_starve_addr", {17'h0, mem_addr}, 32'h008);
    tick();
    i_req = 1'b0;
    sample();
    chk("t4_late_d_gnt", {31'h0, d_gnt}, 32'h1);
    tick();
    d_req = 1'b0;
    sample();
    tick();

    // 5: I/O write ordered behind the buffer, then forced drain
    i_req = 1'b1; i_addr = 16'h0010; dset(1'b1, 1'b1, 16'h0060, 16'hC0DE);
    iq.push_back(16'h1234);
    sample();
    chk("t5_w1_d_gnt", {31'h0, d_gnt}, 32'h1);
    tick();
    dset(1'b1, 1'b1, 16'h0200, 16'h00A5); iq.push_back(16'h1234);
    sample();
    chk("t5_io_blocked", {30'h0, d_gnt, io_en}, 32'h0);
    chk("t5_io_i_gnt", {31'h0, i_gnt}, 32'h1);
    tick();
    i_req = 1'b0;
    sample();
    chk("t5_p4_drain", {30'h0, mem_we, d_gnt}, 32'h2);
    chk("t5_p4_addr", {17'h0, mem_addr}, 32'h030);
    chk("t5_p4_data", {16'h0, mem_wdata}, 32'hC0DE);
    tick();
    sample();
    chk("t5_io_gnt", {28'h0, d_gnt, io_en, io_we, mem_en}, 32'hE);
    chk("t5_io_addr", {24'h0, io_addr}, 32'h00);
    chk("t5_io_wdata", {16'h0, io_wdata}, 32'h00A5);
    tick();
    i_req = 1'b1; dset(1'b1, 1'b1, 16'h0070, 16'h1357); iq.push_back(16'h1234);
    sample();
    chk("t5_w2_gnts", {30'h0, d_gnt, i_gnt}, 32'h3);
    tick();
    dset(1'b1, 1'b1, 16'h0072, 16'h2468);
    sample();
    chk("t5_p2_gnts", {29'h0, d_gnt, i_gnt, mem_we}, 32'h5);
    chk("t5_p2_addr", {17'h0, mem_addr}, 32'h038);
    chk("t5_p2_data", {16'h0, mem_wdata}, 32'h1357);
    tick();
    d_req = 1'b0; iq.push_back(16'h1234);
    sample();
    chk("t5_fetch_after_p2", {31'h0, i_gnt}, 32'h1);
    tick();
    i_req = 1'b0;
    sample();
    chk("t5_p4b", {31'h0, mem_we}, 32'h1);
    chk("t5_p4b_addr", {17'h0, mem_addr}, 32'h039);
    tick();
    dset(1'b1, 1'b0, 16'h0202, 16'h0); dq.push_back(16'h5A5A);
    sample();
    chk("t5_io_rd", {28'h0, d_gnt, io_en, io_we, mem_en}, 32'hC);
    chk("t5_io_rd_addr", {24'h0, io_addr}, 32'h02);
    tick();
    dset(1'b1, 1'b0, 16'h0070, 16'h0); dq.push_back(16'h1357);
    sample();
    chk("t5_rb1_addr", {17'h0, mem_addr}, 32'h038);
    tick();
    dset(1'b1, 1'b0, 16'h0072, 16'h0); dq.push_back(16'h2468);
    sample();
    tick();
    d_req = 1'b0;
    sample();
    chk("t5_led0", {16'h0, io_mem[0]}, 32'h00A5);
    tick();

    // 6: reset discards a posted write and a fetch in flight
    i_req = 1'b1; i_addr = 16'h0010; dset(1'b1, 1'b1, 16'h0080, 16'hDEAD);
    sample();
    chk("t6_w_gnts", {30'h0, d_gnt, i_gnt}, 32'h3);
    tick();
    rst = 1'b1; d_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sample();
      chk($sformatf("t6_rst_strobes%0d", k), {28'h0, i_gnt, mem_en, mem_we, io_en}, 32'h0);
      chk($sformatf("t6_rst_rvalid%0d", k), {30'h0, i_rvalid, d_rvalid}, 32'h0);
      tick();
    end
    rst = 1'b0; i_req = 1'b0;
    sample();
    chk("t6_no_drain", {31'h0, mem_en}, 32'h0);
    chk("t6_rdata_clr", {i_rdata, d_rdata}, 32'h0);
    tick();
    dset(1'b1, 1'b0, 16'h0080, 16'h0); dq.push_back(16'h4444);
    sample();
    chk("t6_rd_gnt", {31'h0, d_gnt}, 32'h1);
    chk("t6_rd_addr", {17'h0, mem_addr}, 32'h040);
    tick();
    d_req = 1'b0;
    sample();
    tick();
    sample();
    tick();

    chk("iq_drained", iq.size(), 32'h0);
    chk("dq_drained", dq.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
